// File: rtl/calc1_req_driver.sv
// rtl/calc1_req_driver.sv - serialises one request onto calc1's cmd/data bus and returns its response
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_cmd/op1/op2       operation and operands captured on the accept edge
//   cmd_in, data_in       calc1 bus: cmd+op1 in the first cycle, op2 in the second
//   resp_in, data_out     calc1 response code and result
//   rsp_valid/rsp_ready   response handshake
//   rsp_status, rsp_data  00 no-op, 01 ok, 10 calc error, 11 timeout; captured result
//   spurious_resp         sticky flag for a calc1 response seen outside WAIT

module calc1_req_driver #(
   parameter int DATA_W  = 32,
   parameter int CMD_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CMD_W-1:0]  req_cmd,
   input  logic [DATA_W-1:0] req_op1,
   input  logic [DATA_W-1:0] req_op2,
   output logic [CMD_W-1:0]  cmd_in,
   output logic [DATA_W-1:0] data_in,
   input  logic [1:0]        resp_in,
   input  logic [DATA_W-1:0] data_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_status,
   output logic [DATA_W-1:0] rsp_data,
   output logic              spurious_resp
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND1,
      S_SEND2,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [CMD_W-1:0]    cmd_d;
   logic [DATA_W-1:0]   data_d;
   logic                valid_d;
   logic [1:0]          status_d;
   logic [DATA_W-1:0]   rdata_d;
   logic                spur_d;

   assign req_ready = (state_q == S_IDLE);

   // Every output except req_ready is registered, so next values are computed
   // here and loaded together with the state. cmd_in/data_in default to zero so
   // the calc1 bus is idle unless a send cycle is being set up.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op2_d    = op2_q;
      cmd_d    = '0;
      data_d   = '0;
      valid_d  = rsp_valid;
      status_d = rsp_status;
      rdata_d  = rsp_data;
      spur_d   = spurious_resp | ((state_q != S_WAIT) && (resp_in != 2'b00));

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op2_d = req_op2;
               cnt_d = '0;
               if (req_cmd == '0) begin
                  // No-op completes locally without touching calc1.
                  state_d  = S_HOLD;
                  valid_d  = 1'b1;
                  status_d = 2'b00;
                  rdata_d  = '0;
               end else begin
                  state_d = S_SEND1;
                  cmd_d   = req_cmd;
                  data_d  = req_op1;
               end
            end
         end
         S_SEND1: begin
            data_d  = op2_q;
            state_d = S_SEND2;
         end
         S_SEND2: begin
            // Counter holds the number of the WAIT cycle currently in progress.
            cnt_d   = CNT_W'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (resp_in != 2'b00) begin
               // A response on the final WAIT cycle still beats the timeout.
               state_d  = S_HOLD;
               valid_d  = 1'b1;
               status_d = resp_in;
               rdata_d  = data_out;
            end else if (cnt_q == TIMEOUT_C) begin
               state_d  = S_HOLD;
               valid_d  = 1'b1;
               status_d = 2'b11;
               rdata_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         op2_q         <= '0;
         cmd_in        <= '0;
         data_in       <= '0;
         rsp_valid     <= 1'b0;
         rsp_status    <= 2'b00;
         rsp_data      <= '0;
         spurious_resp <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op2_q         <= op2_d;
         cmd_in        <= cmd_d;
         data_in       <= data_d;
         rsp_valid     <= valid_d;
         rsp_status    <= status_d;
         rsp_data      <= rdata_d;
         spurious_resp <= spur_d;
      end
   end

endmodule

// File: tb/tb_calc1_req_driver.sv
// tb/tb_calc1_req_driver.sv - self-checking bench for calc1_req_driver

module tb_calc1_req_driver;

   localparam int DATA_W  = 32;
   localparam int CMD_W   = 4;
   localparam int TIMEOUT = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [CMD_W-1:0]  req_cmd;
   logic [DATA_W-1:0] req_op1;
   logic [DATA_W-1:0] req_op2;
   logic [CMD_W-1:0]  cmd_in;
   logic [DATA_W-1:0] data_in;
   logic [1:0]        resp_in;
   logic [DATA_W-1:0] data_out;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_status;
   logic [DATA_W-1:0] rsp_data;
   logic              spurious_resp;

   int vecs = 0;
   int errs = 0;
   logic exp_spur = 1'b0;

   always #5 clk = ~clk;

   calc1_req_driver #(
      .DATA_W  (DATA_W),
      .CMD_W   (CMD_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_cmd       (req_cmd),
      .req_op1       (req_op1),
      .req_op2       (req_op2),
      .cmd_in        (cmd_in),
      .data_in       (data_in),
      .resp_in       (resp_in),
      .data_out      (data_out),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_status    (rsp_status),
      .rsp_data      (rsp_data),
      .spurious_resp (spurious_resp)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // calc1 behaviour assumed by the bench: {code, result}
   function automatic logic [33:0] calc_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'd1:    return {2'b01, a + b};
         4'd2:    return {2'b01, a - b};
         4'd6:    return {2'b01, a >> b[4:0]};
         4'hF:    return {2'b11, 32'd0};
         default: return {2'b10, 32'd0};
      endcase
   endfunction

   // delay = WAIT cycle (1-based) on which calc1 answers; beyond TIMEOUT means never.
   task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input int hold);
      logic [33:0] m;
      logic [1:0]  es;
      logic [31:0] ed;
      m = calc_model(c, a, b);
      if (c == 4'd0) begin
         es = 2'b00; ed = 32'd0;
      end else if (delay >= 1 && delay <= TIMEOUT) begin
         es = m[33:32]; ed = m[31:0];
      end else begin
         es = 2'b11; ed = 32'd0;
      end

      check("idle_req_ready", 64'(req_ready), 64'(1));
      req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b;
      step();
      req_valid = 1'b0; req_cmd = 4'($urandom); req_op1 = $urandom; req_op2 = $urandom;

      if (c != 4'd0) begin
         check("send1_cmd", 64'(cmd_in), 64'(c));
         check("send1_data", 64'(data_in), 64'(a));
         check("send1_req_ready", 64'(req_ready), 64'(0));
         step();
         check("send2_cmd", 64'(cmd_in), 64'(0));
         check("send2_data", 64'(data_in), 64'(b));
         step();
         check("wait_bus_idle", 64'({cmd_in, data_in}), 64'(0));
         for (int k = 1; k <= TIMEOUT; k++) begin
            check("wait_no_rsp", 64'({rsp_valid, req_ready}), 64'(0));
            if (k == delay) begin
               resp_in = m[33:32]; data_out = m[31:0];
            end
            step();
            resp_in = 2'b00; data_out = $urandom;
            if (k == delay) break;
         end
      end

      check("hold_valid", 64'(rsp_valid), 64'(1));
      check("hold_status", 64'(rsp_status), 64'(es));
      check("hold_data", 64'(rsp_data), 64'(ed));
      check("hold_bus_idle", 64'({cmd_in, data_in}), 64'(0));
      for (int h = 0; h < hold; h++) begin
         step();
         check("bp_stable", 64'({rsp_valid, req_ready, rsp_status, rsp_data}),
               64'({1'b1, 1'b0, es, ed}));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("post_hs_valid", 64'(rsp_valid), 64'(0));
      check("post_hs_spur", 64'(spurious_resp), 64'(exp_spur));
   endtask

   initial begin
      logic [3:0] cmds [7];
      int r, d;
      cmds = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'hF};
      reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
      resp_in = 2'b00; data_out = '0; rsp_ready = 1'b0;
      @(negedge clk);
      step();
      reset = 1'b0;
      check("reset_outputs", 64'({cmd_in, rsp_valid, rsp_status, spurious_resp}), 64'(0));
      check("reset_data", 64'({data_in, rsp_data}), 64'(0));
      check("reset_req_ready", 64'(req_ready), 64'(1));

      run_txn(4'd1, 32'd5, 32'd7, 3, 0);
      run_txn(4'd2, 32'd100, 32'd1, 2, 10);
      for (int k = 0; k < 32; k++)
         run_txn(4'd1, 32'd1 << k, 32'd0, $urandom_range(1, 4), 0);
      run_txn(4'd2, 32'd9, 32'd3, TIMEOUT + 10, 1);
      run_txn(4'd1, 32'd20, 32'd22, TIMEOUT, 0);
      run_txn(4'd0, 32'hDEAD, 32'hBEEF, 0, 2);
      run_txn(4'd5, 32'd3, 32'd4, 2, 0);

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) d = TIMEOUT + 5;
         else if (r == 1) d = TIMEOUT;
         else d = $urandom_range(1, 6);
         run_txn(cmds[$urandom_range(0, 6)], $urandom, $urandom, d, $urandom_range(0, 3));
      end

      // Reset in the middle of WAIT, then a late calc1 response.
      req_valid = 1'b1; req_cmd = 4'd1; req_op1 = 32'd1; req_op2 = 32'd2;
      step();
      req_valid = 1'b0;
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midwait_reset_out", 64'({cmd_in, rsp_valid, rsp_status, spurious_resp}), 64'(0));
      check("midwait_reset_data", 64'({data_in, rsp_data}), 64'(0));
      check("midwait_reset_ready", 64'(req_ready), 64'(1));
      resp_in = 2'b01; data_out = 32'd3;
      step();
      resp_in = 2'b00;
      check("late_resp_spur", 64'(spurious_resp), 64'(1));
      check("late_resp_idle", 64'({req_ready, rsp_valid}), 64'(2'b10));

      reset = 1'b1;
      step();
      reset = 1'b0;
      check("spur_cleared", 64'(spurious_resp), 64'(0));
      resp_in = 2'b01;
      step();
      resp_in = 2'b00;
      step();
      check("idle_pulse_spur", 64'(spurious_resp), 64'(1));
      check("idle_pulse_state", 64'({req_ready, rsp_valid}), 64'(2'b10));
      exp_spur = 1'b1;
      run_txn(4'd1, 32'd40, 32'd2, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
